// File: rtl/data_mem_lsu.sv
// data_mem_lsu: handshaked load/store unit for the multi-cycle and pipelined cores.
// Takes one load/store at a time and drives a variable-latency, word-aligned data
// bus with byte enables. An access that crosses a word boundary is split into two
// aligned beats with an idle bus cycle between them. Load bytes are merged, aligned
// and sign/zero-extended into a registered one-cycle response.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, a misaligned access does
// no bus activity and returns an error response instead of being split.
module data_mem_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [2:0]        Lw_Sw_OP,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [XLEN-1:0]   Req_Wdata,
    output logic              Rsp_Valid,
    output logic [XLEN-1:0]   Rsp_Rdata,
    output logic              Rsp_Err,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [XLEN-1:0]   Mem_Wdata,
    output logic [XLEN/8-1:0] Mem_Byte_En,
    input  logic              Mem_Ack,
    input  logic [XLEN-1:0]   Mem_Rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    // wide enough to hold a shift of 8*NB bits
    localparam int SH_W  = OFF_W + 4;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              mem_req_q;
    logic              mem_req_d;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              write_q;
    logic [XLEN-1:0]   ld_q;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [XLEN-1:0]   rsp_rdata_q;

    logic              accept;
    logic              illegal_in;
    logic              trap_in;
    logic              bad_in;

    logic [OFF_W-1:0]  off;
    logic [3:0]        sz;
    logic [4:0]        span;
    logic              split;
    logic [2*NB-1:0]   mask_sz;
    logic [2*NB-1:0]   be_wide;
    logic [2*XLEN-1:0] wd_wide;
    logic [SH_W-1:0]   lo_sh;
    logic [SH_W-1:0]   hi_sh;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] beat1_addr;
    logic [XLEN-1:0]   merge_now;
    logic [XLEN-1:0]   ext_data;
    logic              rsp_err_d;
    logic [XLEN-1:0]   rsp_rdata_d;

    assign Req_Ready = (state_q == IDLE);
    assign accept    = Req_Valid && Req_Ready;

    // Decode opcodes that are never legal for this data width or direction
    always_comb begin
        illegal_in = (Lw_Sw_OP == 3'b111) || (Req_Write && Lw_Sw_OP[2]);
        if ((XLEN == 32) && ((Lw_Sw_OP == 3'b011) || (Lw_Sw_OP == 3'b110))) begin
            illegal_in = 1'b1;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic [3:0] sz_in;
    logic [2:0] align_mask;
    assign sz_in      = 4'd1 << Lw_Sw_OP[1:0];
    assign align_mask = 3'(sz_in - 4'd1);
    assign trap_in    = (Req_Addr[2:0] & align_mask) != 3'b000;
`else
    assign trap_in    = 1'b0;
`endif

    assign bad_in = illegal_in || trap_in;

    // Geometry of the latched access: byte offset, size and whether it spills over
    assign off        = addr_q[OFF_W-1:0];
    assign sz         = 4'd1 << op_q[1:0];
    assign span       = 5'(off) + 5'(sz);
    assign split      = span > 5'(NB);
    assign lo_sh      = SH_W'({off, 3'b000});
    assign hi_sh      = SH_W'(8 * NB) - lo_sh;
    assign aligned    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign beat1_addr = aligned + ADDR_W'(NB);
    assign be_wide    = mask_sz << off;
    assign wd_wide    = {{XLEN{1'b0}}, wdata_q} << lo_sh;

    // Build a run of SZ ones that is shifted into lane position across two words
    always_comb begin
        mask_sz = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            mask_sz[i] = (i < int'(sz));
        end
    end

    // Merge bus read data: beat0 supplies the low result bytes, beat1 the rest
    always_comb begin
        merge_now = Mem_Rdata >> lo_sh;
        if (state_q == BEAT1) begin
            merge_now = ld_q | (Mem_Rdata << hi_sh);
        end
    end

    // Sign- or zero-extend the merged bytes from bit 8*SZ-1
    always_comb begin
        int  nbits;
        logic sign_bit;
        nbits    = 8 * int'(sz);
        sign_bit = 1'b0;
        ext_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == nbits - 1) begin
                sign_bit = merge_now[i];
            end
        end
        for (int i = 0; i < XLEN; i++) begin
            ext_data[i] = (i < nbits) ? merge_now[i] : (sign_bit & ~op_q[2]);
        end
    end

    // Only a rejected request goes straight from IDLE to RESP, so that path carries the error
    always_comb begin
        rsp_err_d   = (state_q == IDLE);
        rsp_rdata_d = ext_data;
        if ((state_q == IDLE) || write_q) begin
            rsp_rdata_d = '0;
        end
    end

    // Next-state and bus-request sequencing, including the idle cycle between beats
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_in) begin
                        state_d = RESP;
                    end else begin
                        state_d   = BEAT0;
                        mem_req_d = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (Mem_Ack) begin
                    mem_req_d = 1'b0;
                    state_d   = split ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (Mem_Ack) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State register and bus request flag; reset drops Mem_Req at once
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
        end
    end

    // Latch the request on accept and collect load bytes as each beat completes
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ld_q    <= '0;
        end else begin
            if (accept) begin
                op_q    <= Lw_Sw_OP;
                addr_q  <= Req_Addr;
                wdata_q <= Req_Wdata;
                write_q <= Req_Write;
            end
            if (Mem_Ack && mem_req_q && ((state_q == BEAT0) || (state_q == BEAT1))) begin
                ld_q <= merge_now;
            end
        end
    end

    // Registered response: one-cycle valid pulse, data and error hold until the next one
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (state_d == RESP) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end else begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_Err   = rsp_err_q;
    assign Rsp_Rdata = rsp_rdata_q;

    // Bus outputs come only from registers, so they stay stable for the whole beat
    always_comb begin
        Mem_Req     = mem_req_q;
        Mem_We      = 1'b0;
        Mem_Addr    = '0;
        Mem_Wdata   = '0;
        Mem_Byte_En = '0;
        if (mem_req_q) begin
            Mem_We = write_q;
            if (state_q == BEAT1) begin
                Mem_Addr    = beat1_addr;
                Mem_Wdata   = wd_wide[2*XLEN-1:XLEN];
                Mem_Byte_En = be_wide[2*NB-1:NB];
            end else begin
                Mem_Addr    = aligned;
                Mem_Wdata   = wd_wide[XLEN-1:0];
                Mem_Byte_En = be_wide[NB-1:0];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: scoreboard bench for data_mem_lsu (XLEN=32). A byte-level memory
// model predicts every bus beat and every response; a bus responder with variable
// ack latency checks beats, and a monitor checks responses as they appear.
module tb_data_mem_lsu;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int NB     = XLEN / 8;

    logic              Clk;
    logic              Rst_N;
    logic              Req_Valid;
    logic              Req_Ready;
    logic              Req_Write;
    logic [2:0]        Lw_Sw_OP;
    logic [ADDR_W-1:0] Req_Addr;
    logic [XLEN-1:0]   Req_Wdata;
    logic              Rsp_Valid;
    logic [XLEN-1:0]   Rsp_Rdata;
    logic              Rsp_Err;
    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [XLEN-1:0]   Mem_Wdata;
    logic [NB-1:0]     Mem_Byte_En;
    logic              Mem_Ack;
    logic [XLEN-1:0]   Mem_Rdata;

    typedef struct {
        logic [31:0]     addr;
        logic [NB-1:0]   be;
        logic [XLEN-1:0] wdata;
        logic            we;
    } beat_t;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            err;
    } rsp_t;

    beat_t      beat_q[$];
    rsp_t       rsp_q[$];
    logic [7:0] ref_mem[logic [31:0]];
    logic [7:0] bus_mem[logic [31:0]];

    int checks    = 0;
    int errors    = 0;
    int ack_delay = 0;

    data_mem_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .Clk        (Clk),
        .Rst_N      (Rst_N),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Req_Write  (Req_Write),
        .Lw_Sw_OP   (Lw_Sw_OP),
        .Req_Addr   (Req_Addr),
        .Req_Wdata  (Req_Wdata),
        .Rsp_Valid  (Rsp_Valid),
        .Rsp_Rdata  (Rsp_Rdata),
        .Rsp_Err    (Rsp_Err),
        .Mem_Req    (Mem_Req),
        .Mem_We     (Mem_We),
        .Mem_Addr   (Mem_Addr),
        .Mem_Wdata  (Mem_Wdata),
        .Mem_Byte_En(Mem_Byte_En),
        .Mem_Ack    (Mem_Ack),
        .Mem_Rdata  (Mem_Rdata)
    );

    // Free-running clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Runaway guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual still running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual timeout/unexpected required expected event", name);
    endtask

    function automatic logic [7:0] initByte(input logic [31:0] a);
        logic [31:0] t;
        t = (a * 32'd37) ^ (a >> 5) ^ 32'h5A;
        return t[7:0];
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return initByte(a);
    endfunction

    function automatic logic [7:0] busByte(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return initByte(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] word);
        for (int k = 0; k < 4; k++) begin
            ref_mem[a + 32'(k)] = word[8*k +: 8];
            bus_mem[a + 32'(k)] = word[8*k +: 8];
        end
    endtask

    // Reference model: walk the accessed bytes, group them by aligned word into beats
    function automatic void modelRequest(input logic wr, input logic [2:0] op,
                                         input logic [31:0] addr, input logic [XLEN-1:0] wdata);
        int          sz;
        int          lane;
        bit          bad;
        bit          have;
        rsp_t        r;
        beat_t       b;
        logic [63:0] val;
        logic [31:0] a;
        logic [31:0] w;
        sz  = 1 << op[1:0];
        bad = (op == 3'b111) || (wr && op[2]) || ((XLEN == 32) && ((op == 3'b011) || (op == 3'b110)));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((addr % 32'(sz)) != 0) bad = 1'b1;
`endif
        r.rdata = '0;
        r.err   = bad;
        b.addr  = '0;
        b.be    = '0;
        b.wdata = '0;
        b.we    = wr;
        val     = '0;
        have    = 1'b0;
        if (!bad) begin
            for (int k = 0; k < sz; k++) begin
                a    = addr + 32'(k);
                w    = a & ~32'(NB - 1);
                lane = int'(a % 32'(NB));
                if (!have || (w != b.addr)) begin
                    if (have) beat_q.push_back(b);
                    b.addr  = w;
                    b.be    = '0;
                    b.wdata = '0;
                    b.we    = wr;
                    have    = 1'b1;
                end
                b.be[lane] = 1'b1;
                if (wr) begin
                    b.wdata[8*lane +: 8] = wdata[8*k +: 8];
                    ref_mem[a]           = wdata[8*k +: 8];
                end else begin
                    val[8*k +: 8] = refByte(a);
                end
            end
            beat_q.push_back(b);
            if (!wr) begin
                if (!op[2] && (8 * sz < 64) && val[8*sz-1]) begin
                    val = val | ~((64'd1 << (8 * sz)) - 64'd1);
                end
                r.rdata = val[XLEN-1:0];
            end
        end
        rsp_q.push_back(r);
    endfunction

    // Present one request at a negedge, predict its outcome, hold it over the accepting edge
    task automatic applyStimulus(input logic wr, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [XLEN-1:0] wdata);
        int n;
        n = 0;
        @(negedge Clk);
        while (!Req_Ready && (n < 50)) begin
            @(negedge Clk);
            n++;
        end
        if (!Req_Ready) begin
            failNow("req_ready_timeout");
            return;
        end
        modelRequest(wr, op, addr, wdata);
        Req_Valid = 1'b1;
        Req_Write = wr;
        Lw_Sw_OP  = op;
        Req_Addr  = addr;
        Req_Wdata = wdata;
        @(posedge Clk);
        #1;
        Req_Valid = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            #1;
            n++;
        end while (((rsp_q.size() != 0) || (beat_q.size() != 0) || !Req_Ready) && (n < 60));
        if ((rsp_q.size() != 0) || (beat_q.size() != 0)) begin
            failNow("response_timeout");
            rsp_q.delete();
            beat_q.delete();
        end
    endtask

    // Response monitor: every Rsp_Valid pulse must match the oldest prediction
    initial begin
        rsp_t e;
        forever begin
            @(negedge Clk);
            if (Rst_N && Rsp_Valid) begin
                if (rsp_q.size() == 0) begin
                    failNow("unexpected_rsp");
                end else begin
                    e = rsp_q.pop_front();
                    checkOutput("rsp_rdata", 64'(Rsp_Rdata), 64'(e.rdata));
                    checkOutput("rsp_err", 64'(Rsp_Err), 64'(e.err));
                end
            end
        end
    end

    // Bus responder: acks after a chosen delay, checks beat contents and stability
    initial begin
        bit              in_beat;
        int              wait_cnt;
        logic [63:0]     snap;
        logic [63:0]     cur;
        logic [XLEN-1:0] lmask;
        beat_t           eb;
        in_beat   = 1'b0;
        wait_cnt  = 0;
        snap      = '0;
        Mem_Ack   = 1'b0;
        Mem_Rdata = '0;
        forever begin
            @(negedge Clk);
            Mem_Ack = 1'b0;
            cur = {Mem_Addr, Mem_Wdata[27:0], Mem_Byte_En} ^ {63'd0, Mem_We};
            if (!Mem_Req) begin
                in_beat = 1'b0;
            end else begin
                if (!in_beat) begin
                    in_beat  = 1'b1;
                    snap     = cur;
                    wait_cnt = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                    if (beat_q.size() == 0) failNow("unexpected_beat");
                end else begin
                    checkOutput("bus_stable", cur, snap);
                end
                if (wait_cnt == 0) begin
                    for (int l = 0; l < NB; l++) begin
                        Mem_Rdata[8*l +: 8] = busByte(Mem_Addr + 32'(l));
                        if (Mem_We && Mem_Byte_En[l]) bus_mem[Mem_Addr + 32'(l)] = Mem_Wdata[8*l +: 8];
                    end
                    if (beat_q.size() != 0) begin
                        eb = beat_q.pop_front();
                        checkOutput("beat_addr", 64'(Mem_Addr), 64'(eb.addr));
                        checkOutput("beat_be", 64'(Mem_Byte_En), 64'(eb.be));
                        checkOutput("beat_we", 64'(Mem_We), 64'(eb.we));
                        if (eb.we) begin
                            for (int l = 0; l < NB; l++) lmask[8*l +: 8] = {8{eb.be[l]}};
                            checkOutput("beat_wdata", 64'(Mem_Wdata & lmask), 64'(eb.wdata));
                        end
                    end
                    Mem_Ack = 1'b1;
                    in_beat = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Directed scenarios, then randomized traffic
    initial begin
        int          n;
        logic [31:0] target;
        logic        exp_err;
        Rst_N     = 1'b0;
        Req_Valid = 1'b0;
        Req_Write = 1'b0;
        Lw_Sw_OP  = 3'b000;
        Req_Addr  = '0;
        Req_Wdata = '0;
        repeat (2) @(negedge Clk);
        checkOutput("rst_rsp_valid", 64'(Rsp_Valid), 64'd0);
        checkOutput("rst_rsp_err", 64'(Rsp_Err), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(Rsp_Rdata), 64'd0);
        checkOutput("rst_mem_req", 64'(Mem_Req), 64'd0);
        checkOutput("rst_mem_we", 64'(Mem_We), 64'd0);
        checkOutput("rst_mem_addr", 64'(Mem_Addr), 64'd0);
        checkOutput("rst_mem_wdata", 64'(Mem_Wdata), 64'd0);
        checkOutput("rst_mem_be", 64'(Mem_Byte_En), 64'd0);
        Rst_N = 1'b1;
        @(negedge Clk);
        checkOutput("ready_after_reset", 64'(Req_Ready), 64'd1);

        // LW aligned, same-cycle ack: response two cycles after accept
        ack_delay = 0;
        preload(32'h100, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b010, 32'h100, '0);
        @(negedge Clk);
        checkOutput("lw_mem_req", 64'(Mem_Req), 64'd1);
        checkOutput("lw_be", 64'(Mem_Byte_En), 64'hF);
        checkOutput("lw_no_early_rsp", 64'(Rsp_Valid), 64'd0);
        @(negedge Clk);
        checkOutput("lw_rsp_latency", 64'(Rsp_Valid), 64'd1);
        checkOutput("lw_rdata", 64'(Rsp_Rdata), 64'hDEADBEEF);
        waitDone();

        // LB / LBU of the top byte lane
        preload(32'h100, 32'h80123456);
        applyStimulus(1'b0, 3'b000, 32'h103, '0);
        @(negedge Clk);
        checkOutput("lb_be", 64'(Mem_Byte_En), 64'b1000);
        waitDone();
        checkOutput("lb_rdata_hold", 64'(Rsp_Rdata), 64'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h103, '0);
        waitDone();
        checkOutput("lbu_rdata_hold", 64'(Rsp_Rdata), 64'h00000080);

        // SH into the upper half word
        applyStimulus(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
        @(negedge Clk);
        checkOutput("sh_wdata", 64'(Mem_Wdata), 64'hABCD0000);
        checkOutput("sh_be", 64'(Mem_Byte_En), 64'b1100);
        checkOutput("sh_we", 64'(Mem_We), 64'd1);
        waitDone();

        // SW crossing a word boundary
`ifdef LSU_MISALIGN_TRAP_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        applyStimulus(1'b1, 3'b010, 32'h103, 32'h11223344);
        waitDone();
        checkOutput("sw_split_err", 64'(Rsp_Err), 64'(exp_err));

        // Split LW with three-cycle ack delay per beat
        ack_delay = 3;
        preload(32'h100, 32'hAAAA5566);
        preload(32'h104, 32'h77887788);
        applyStimulus(1'b0, 3'b010, 32'h102, '0);
        n = 0;
        while (n < 40) begin
            @(negedge Clk);
            if (Rsp_Valid) break;
            checkOutput("ready_while_busy", 64'(Req_Ready), 64'd0);
            n++;
        end
        if (n >= 40) failNow("split_lw_timeout");
        waitDone();
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("split_lw_err", 64'(Rsp_Err), 64'd1);
`else
        checkOutput("split_lw_rdata", 64'(Rsp_Rdata), 64'h7788AAAA);
`endif

        // Reset in the middle of the second beat abandons the load
`ifdef LSU_MISALIGN_TRAP_EN
        target = 32'h100;
        applyStimulus(1'b0, 3'b010, 32'h100, '0);
`else
        target = 32'h104;
        applyStimulus(1'b0, 3'b010, 32'h102, '0);
`endif
        n = 0;
        while (n < 40) begin
            @(negedge Clk);
            #2;
            if (Mem_Req && (Mem_Addr == target)) break;
            n++;
        end
        if (n >= 40) failNow("beat_wait_timeout");
        Rst_N = 1'b0;
        #1;
        checkOutput("reset_drops_req", 64'(Mem_Req), 64'd0);
        checkOutput("reset_no_rsp", 64'(Rsp_Valid), 64'd0);
        rsp_q.delete();
        beat_q.delete();
        repeat (2) @(negedge Clk);
        Rst_N = 1'b1;
        repeat (3) @(negedge Clk);
        checkOutput("ready_after_midreset", 64'(Req_Ready), 64'd1);

        // Illegal op 111: error one cycle after accept, no bus request
        ack_delay = 0;
        applyStimulus(1'b0, 3'b111, 32'h100, '0);
        @(negedge Clk);
        checkOutput("illegal_rsp_valid", 64'(Rsp_Valid), 64'd1);
        checkOutput("illegal_err", 64'(Rsp_Err), 64'd1);
        checkOutput("illegal_no_req", 64'(Mem_Req), 64'd0);
        waitDone();

        // Address wrap on the second beat
        applyStimulus(1'b0, 3'b010, 32'hFFFFFFFE, '0);
        waitDone();

        // Randomized traffic with random ack latency
        ack_delay = -1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            if ($urandom_range(0, 15) == 0) ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else ra = 32'h100 + 32'($urandom_range(0, 63));
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
            waitDone();
        end

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised, handshaked successor to the single-cycle data memory controller, for the multi-cycle and pipelined cores.
- Accepts one load/store request at a time from the core and drives a variable-latency, word-aligned data memory bus with byte enables.
- Splits accesses that cross a word boundary into two aligned bus beats, then merges, aligns and sign/zero-extends load data.
- Returns one registered response per request.

Parameters:
- XLEN, 32, data word width; legal values 32 or 64; NB = XLEN/8 byte lanes, OFF_W = log2(NB).
- ADDR_W, 32, byte-address width.

Ports:
- Clk  input  1  system clock; rising edge.
- Rst_N  input  1  asynchronous active-low reset.
- Req_Valid  input  1  core request valid.
- Req_Ready  output  1  block can accept a request.
- Req_Write  input  1  1 = store, 0 = load.
- Lw_Sw_OP  input  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- Req_Addr  input  ADDR_W  byte address.
- Req_Wdata  input  XLEN  store data, right-justified.
- Rsp_Valid  output  1  one-cycle response pulse.
- Rsp_Rdata  output  XLEN  load result, extended; 0 for stores.
- Rsp_Err  output  1  access error, qualified by Rsp_Valid.
- Mem_Req  output  1  bus request; held until Mem_Ack.
- Mem_We  output  1  bus write.
- Mem_Addr  output  ADDR_W  aligned address; low OFF_W bits are always 0.
- Mem_Wdata  output  XLEN  lane-positioned write data.
- Mem_Byte_En  output  NB  byte-lane enables.
- Mem_Ack  input  1  bus completion; read data valid in the same cycle.
- Mem_Rdata  input  XLEN  bus read data.

Behaviour:
- Reset (asynchronous, Rst_N low):
  - State goes to IDLE.
  - Req_Ready=1 (after reset is released).
  - Rsp_Valid=0, Rsp_Err=0, Rsp_Rdata=0.
  - Mem_Req=0, Mem_We=0, Mem_Addr=0, Mem_Wdata=0, Mem_Byte_En=0.
  - Reset mid-transaction drops Mem_Req immediately and abandons the request with no response.
- Access size: SZ = 1, 2, 4 or 8 bytes from Lw_Sw_OP[1:0]. Lw_Sw_OP[2] selects zero-extension on loads.
- Illegal ops, accepted but producing no bus activity:
  - 111 always.
  - 011 and 110 when XLEN=32.
  - Bit 2 set on a store.
  - Response is one cycle after accept with Rsp_Err=1.
- States: IDLE, BEAT0, BEAT1, RESP.
  - Req_Ready = (state==IDLE).
- IDLE:
  - Req_Valid & Req_Ready latches the request: op, addr, wdata, write.
  - Next state is BEAT0, or RESP for an illegal op.
- BEAT0:
  - Mem_Addr = addr with the low OFF_W bits cleared.
  - Mem_Byte_En = ((1<<SZ)-1) << off, truncated to NB lanes.
  - Mem_Wdata = wdata << (8*off).
  - Hold all bus outputs stable until Mem_Ack.
  - On Mem_Ack, a load captures the upper lanes.
  - Next state is BEAT1 if off+SZ > NB, else RESP.
- BEAT1:
  - Mem_Addr = aligned addr + NB, wrapping modulo 2^ADDR_W.
  - Mem_Byte_En = (1<<(off+SZ-NB))-1.
  - Mem_Wdata = wdata >> (8*(NB-off)).
  - On Mem_Ack, next state is RESP.
- Mem_Req deasserts in the cycle after Mem_Ack, with one idle bus cycle between beats.
- RESP:
  - Rsp_Valid=1 for exactly one cycle.
  - Rsp_Rdata is the merged bytes, sign- or zero-extended from bit 8*SZ-1.
  - Next state is IDLE; a new request can be accepted in the following cycle.
- Latency: accept at cycle T, Mem_Req at T+1, Rsp_Valid at T+1+N+1, where N is the number of cycles until Mem_Ack per beat.
- Mem_Ack outside BEAT0/BEAT1 is ignored.
- Response outputs hold their values until the next response. Rsp_Valid is the only pulse.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A request with addr mod SZ != 0 does no bus activity.
  - Next state is RESP with Rsp_Err=1 and Rsp_Rdata=0.
  - BEAT1 is unreachable.
- Undefined: misaligned accesses are split as above and Rsp_Err flags illegal ops only.

Test Plan:
- XLEN=32, LW addr 0x100, Mem_Rdata=0xDEADBEEF, ack same cycle -> Mem_Byte_En=1111, Rsp_Rdata=0xDEADBEEF, Rsp_Valid at T+2.
- LB addr 0x103, Mem_Rdata=0x80123456 -> Byte_En=1000, Rsp_Rdata=0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr 0x102, Req_Wdata=0x0000ABCD -> Byte_En=1100, Mem_Wdata=0xABCD0000, Mem_We=1, single beat.
- SW addr 0x103, Req_Wdata=0x11223344:
  - Beat0 addr 0x100, Byte_En=1000, Mem_Wdata[31:24]=0x44.
  - Beat1 addr 0x104, Byte_En=0111, Mem_Wdata[23:0]=0x112233.
  - With LSU_MISALIGN_TRAP_EN: no Mem_Req, Rsp_Err=1.
- LW addr 0x102 with Mem_Ack delayed 3 cycles per beat, beat0 data 0xAAAA5566, beat1 data 0x77887788:
  - Mem_Req held stable throughout each beat.
  - Rsp_Rdata=0x7788AAAA.
  - Req_Ready=0 until RESP.
- Rst_N low during BEAT1 -> Mem_Req=0 immediately, no Rsp_Valid; Lw_Sw_OP=111 after reset -> Rsp_Err=1 at T+1, no Mem_Req.
